branch_predictor: RTL and testbench

Parametrised branch-prediction and resolution unit for the five-stage core. It replaces the fixed "assume taken" policy in decode with a selectable static or bimodal (2-bit saturating counter) predictor. It resolves B-type conditions in Execute (signed and unsigned), drives the next-PC select with distinct recovery codes for each misprediction direction, and keeps saturating branch/mispredict statistics. It sits beside the decoder: prediction happens in Decode, and resolution and table update happen in Execute.

---
 rtl/bp_pkg.sv | 47 ++++
 rtl/bht_table.sv | 37 +++
 rtl/branch_predictor.sv | 156 +++++++++++++++
 tb/tb_branch_predictor.sv | 256 +++++++++++++++++++++++++
 4 files changed

// File: rtl/bp_pkg.sv
// Shared types and constants for the branch prediction / resolution unit.
package bp_pkg;

  // Next-PC select codes
  typedef enum logic [1:0] {
    PC_INC     = 2'b00,  // sequential PC+4
    PC_PRED    = 2'b01,  // predicted-taken branch or JAL target from Decode
    PC_BR_TGT  = 2'b10,  // predicted not-taken, actually taken: branch target from Execute
    PC_RECOVER = 2'b11   // predicted taken, actually not taken: pc_E + 4
  } pcsrc_e;

  // B-type funct3 encodings
  localparam logic [2:0] F3_BEQ  = 3'b000;
  localparam logic [2:0] F3_BNE  = 3'b001;
  localparam logic [2:0] F3_BLT  = 3'b100;
  localparam logic [2:0] F3_BGE  = 3'b101;
  localparam logic [2:0] F3_BLTU = 3'b110;
  localparam logic [2:0] F3_BGEU = 3'b111;

  // 2-bit saturating counter states
  typedef enum logic [1:0] {
    CTR_SNT = 2'b00,  // strongly not-taken
    CTR_WNT = 2'b01,  // weakly not-taken
    CTR_WT  = 2'b10,  // weakly taken
    CTR_ST  = 2'b11   // strongly taken
  } ctr_state_e;

  // Prediction policies
  localparam int MODE_STATIC_T  = 0;
  localparam int MODE_BIMODAL   = 1;
  localparam int MODE_STATIC_NT = 2;

  // True for the six defined B-type conditions; 010/011 are reserved
  function automatic logic f3_is_branch(input logic [2:0] f3);
    return (f3 != 3'b010) && (f3 != 3'b011);
  endfunction

  // Saturating step of a 2-bit counter toward the resolved outcome
  function automatic logic [1:0] ctr_next(input logic [1:0] ctr, input logic taken);
    logic [1:0] nxt;
    nxt = ctr;
    if (taken && (ctr != CTR_ST))       nxt = ctr + 2'd1;
    else if (!taken && (ctr != CTR_SNT)) nxt = ctr - 2'd1;
    return nxt;
  endfunction

endpackage

// File: rtl/bht_table.sv
// Branch history table: array of 2-bit saturating counters with one
// asynchronous read port (Decode) and one update port (Execute).
module bht_table
  import bp_pkg::*;
#(
  parameter int         ENTRIES    = 16,
  parameter logic [1:0] INIT_STATE = 2'b01,
  parameter int         IDX_W      = $clog2(ENTRIES)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [IDX_W-1:0] i_rd_idx,
  output logic [1:0]       o_rd_ctr,
  input  logic             i_wr_en,
  input  logic [IDX_W-1:0] i_wr_idx,
  input  logic             i_wr_taken
);

  logic [1:0] r_ctr [ENTRIES];

  // Counter storage: reinitialise on reset, saturating update on resolve
  // NOTE: this array is held in flops rather than a RAM macro because every
  // entry must return to INIT_STATE on reset; a RAM could not be cleared in
  // one asynchronous step. Non-blocking assignments keep same-edge reads of
  // r_ctr seeing the pre-edge value.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < ENTRIES; i++) r_ctr[i] <= INIT_STATE;
    end else if (i_wr_en) begin
      r_ctr[i_wr_idx] <= ctr_next(r_ctr[i_wr_idx], i_wr_taken);
    end
  end

  // Asynchronous read: a same-cycle write is not bypassed to Decode
  assign o_rd_ctr = r_ctr[i_rd_idx];

endmodule

// File: rtl/branch_predictor.sv
// Branch prediction (Decode) and resolution (Execute) unit with selectable
// static / bimodal policy, next-PC select and saturating statistics.
module branch_predictor
  import bp_pkg::*;
#(
  parameter int         XLEN         = 32,
  parameter int         ENTRIES      = 16,
  parameter int         INDEX_LSB    = 2,
  parameter int         PREDICT_MODE = 1,
  parameter logic [1:0] INIT_STATE   = 2'b01,
  parameter int         CNT_W        = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [XLEN-1:0]  pc_D,
  input  logic             branch_D,
  input  logic             jump_D,
  input  logic             stall_D,
  input  logic             flush_D,
  input  logic [XLEN-1:0]  pc_E,
  input  logic [2:0]       funct3_E,
  input  logic             N,
  input  logic             Z,
  input  logic             C,
  input  logic             V,
  input  logic             stats_clr,
  output logic             predict_taken_D,
  output logic [1:0]       PCSrc,
  output logic             condition_met_E,
  output logic             mispredict_E,
  output logic [CNT_W-1:0] branch_cnt,
  output logic [CNT_W-1:0] mispredict_cnt
);

  localparam int IDX_W = $clog2(ENTRIES);

  logic [IDX_W-1:0] w_idx_D;
  logic [IDX_W-1:0] w_idx_E;
  logic [1:0]       w_ctr_D;
  logic             w_pred_D;
  logic             w_cond_met;
  logic             w_mispredict;
  logic             w_upd_en;
  pcsrc_e           w_pcsrc;
  logic             w_unused;

  logic             r_branch_v_E;
  logic             r_pred_E;
  logic [CNT_W-1:0] r_branch_cnt;
  logic [CNT_W-1:0] r_mispredict_cnt;

  // Same index function for both stages
  assign w_idx_D = pc_D[INDEX_LSB +: IDX_W];
  assign w_idx_E = pc_E[INDEX_LSB +: IDX_W];

  // Resolved B-type branch with a defined condition trains the table
  assign w_upd_en = r_branch_v_E & f3_is_branch(funct3_E);

  generate
    if (PREDICT_MODE == MODE_BIMODAL) begin : g_bht
      bht_table #(
        .ENTRIES    (ENTRIES),
        .INIT_STATE (INIT_STATE),
        .IDX_W      (IDX_W)
      ) u_bht (
        .clk        (clk),
        .reset      (reset),
        .i_rd_idx   (w_idx_D),
        .o_rd_ctr   (w_ctr_D),
        .i_wr_en    (w_upd_en),
        .i_wr_idx   (w_idx_E),
        .i_wr_taken (w_cond_met)
      );
    end else begin : g_no_bht
      assign w_ctr_D = CTR_SNT;
    end
  endgenerate

  // PC bits outside the index field (and the table signals in static modes)
  // are intentionally not consumed
  assign w_unused = ^{pc_D, pc_E, w_ctr_D, w_upd_en, w_idx_E};

  // Decode-stage prediction according to the selected policy
  // NOTE: every always_comb output gets a default before any branch so no
  // path can leave it unassigned and infer a latch.
  always_comb begin
    w_pred_D = 1'b0;
    case (PREDICT_MODE)
      MODE_STATIC_T: w_pred_D = branch_D;
      MODE_BIMODAL:  w_pred_D = branch_D & w_ctr_D[1];
      default:       w_pred_D = 1'b0;
    endcase
  end

  // D->E pipeline of branch-valid and prediction; a mispredict kills the
  // entry even when Decode is stalled
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_branch_v_E <= 1'b0;
      r_pred_E     <= 1'b0;
    end else begin
      if (!stall_D) begin
        r_branch_v_E <= branch_D & ~flush_D;
        r_pred_E     <= w_pred_D;
      end
      if (w_mispredict) r_branch_v_E <= 1'b0;
    end
  end

  // Execute-stage condition resolution from the A-B flags
  always_comb begin
    w_cond_met = 1'b0;
    if (r_branch_v_E) begin
      case (funct3_E)
        F3_BEQ:  w_cond_met = Z;
        F3_BNE:  w_cond_met = ~Z;
        F3_BLT:  w_cond_met = N ^ V;
        F3_BGE:  w_cond_met = ~(N ^ V);
        F3_BLTU: w_cond_met = ~C;
        F3_BGEU: w_cond_met = C;
        default: w_cond_met = 1'b0;
      endcase
    end
  end

  assign w_mispredict = r_branch_v_E & (w_cond_met != r_pred_E);

  // Next-PC select: recovery from Execute outranks anything in Decode
  always_comb begin
    w_pcsrc = PC_INC;
    if (w_mispredict)                       w_pcsrc = w_cond_met ? PC_BR_TGT : PC_RECOVER;
    else if ((branch_D & w_pred_D) | jump_D) w_pcsrc = PC_PRED;
  end

  // Resolved-branch counter: clear wins, otherwise saturating increment
  always_ff @(posedge clk or posedge reset) begin
    if (reset)                                          r_branch_cnt <= '0;
    else if (stats_clr)                                 r_branch_cnt <= '0;
    else if (r_branch_v_E && (r_branch_cnt != '1))      r_branch_cnt <= r_branch_cnt + 1'b1;
  end

  // Misprediction counter: clear wins, otherwise saturating increment
  always_ff @(posedge clk or posedge reset) begin
    if (reset)                                          r_mispredict_cnt <= '0;
    else if (stats_clr)                                 r_mispredict_cnt <= '0;
    else if (w_mispredict && (r_mispredict_cnt != '1))  r_mispredict_cnt <= r_mispredict_cnt + 1'b1;
  end

  assign predict_taken_D = w_pred_D;
  assign PCSrc           = w_pcsrc;
  assign condition_met_E = w_cond_met;
  assign mispredict_E    = w_mispredict;
  assign branch_cnt      = r_branch_cnt;
  assign mispredict_cnt  = r_mispredict_cnt;

endmodule

// File: tb/tb_branch_predictor.sv
// Self-checking bench: a bimodal instance and a static-taken instance with
// narrow statistics counters share one stimulus stream and are compared
// every cycle against a behavioural model derived from operand values.
module tb_branch_predictor;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] pc_D, pc_E;
  logic        branch_D, jump_D, stall_D, flush_D, stats_clr;
  logic [2:0]  funct3_E;
  logic        N, Z, C, V;

  logic        pt1, cm1, mis1;
  logic [1:0]  pcs1;
  logic [15:0] bc1, mc1;
  logic        pt0, cm0, mis0;
  logic [1:0]  pcs0;
  logic [3:0]  bc0, mc0;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  branch_predictor #(.PREDICT_MODE(1)) dut (
    .clk(clk), .reset(reset), .pc_D(pc_D), .branch_D(branch_D), .jump_D(jump_D),
    .stall_D(stall_D), .flush_D(flush_D), .pc_E(pc_E), .funct3_E(funct3_E),
    .N(N), .Z(Z), .C(C), .V(V), .stats_clr(stats_clr),
    .predict_taken_D(pt1), .PCSrc(pcs1), .condition_met_E(cm1),
    .mispredict_E(mis1), .branch_cnt(bc1), .mispredict_cnt(mc1)
  );

  branch_predictor #(.PREDICT_MODE(0), .CNT_W(4)) dut0 (
    .clk(clk), .reset(reset), .pc_D(pc_D), .branch_D(branch_D), .jump_D(jump_D),
    .stall_D(stall_D), .flush_D(flush_D), .pc_E(pc_E), .funct3_E(funct3_E),
    .N(N), .Z(Z), .C(C), .V(V), .stats_clr(stats_clr),
    .predict_taken_D(pt0), .PCSrc(pcs0), .condition_met_E(cm0),
    .mispredict_E(mis0), .branch_cnt(bc0), .mispredict_cnt(mc0)
  );

  // ---------------- reference model ----------------
  // index 0 = bimodal instance, index 1 = static-taken instance
  int m_ctr [16];
  bit m_v [2];
  bit m_pred [2];
  int m_bcnt [2];
  int m_mcnt [2];
  int m_max [2] = '{65535, 15};
  bit e_pd [2];
  bit e_cond [2];
  bit e_mis [2];
  int e_pcs [2];
  logic [31:0] s_a, s_b;

  function automatic bit ref_cond(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
    case (f3)
      3'd0:    return a == b;
      3'd1:    return a != b;
      3'd4:    return $signed(a) < $signed(b);
      3'd5:    return $signed(a) >= $signed(b);
      3'd6:    return a < b;
      3'd7:    return a >= b;
      default: return 1'b0;
    endcase
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 16; i++) m_ctr[i] = 1;
    for (int k = 0; k < 2; k++) begin
      m_v[k] = 0; m_pred[k] = 0; m_bcnt[k] = 0; m_mcnt[k] = 0;
    end
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Compute expected combinational outputs from model state and inputs, compare
  task automatic check_all();
    int idx;
    idx = int'((pc_D >> 2) % 16);
    for (int k = 0; k < 2; k++) begin
      if (k == 0) e_pd[k] = branch_D && (m_ctr[idx] >= 2);
      else        e_pd[k] = branch_D;
      e_cond[k] = m_v[k] ? ref_cond(funct3_E, s_a, s_b) : 1'b0;
      e_mis[k]  = m_v[k] && (e_cond[k] != m_pred[k]);
      if (e_mis[k])                           e_pcs[k] = e_cond[k] ? 2 : 3;
      else if ((branch_D && e_pd[k]) || jump_D) e_pcs[k] = 1;
      else                                    e_pcs[k] = 0;
    end
    check("m1_pred",   32'(pt1),  32'(e_pd[0]));
    check("m1_cond",   32'(cm1),  32'(e_cond[0]));
    check("m1_mis",    32'(mis1), 32'(e_mis[0]));
    check("m1_pcsrc",  32'(pcs1), 32'(e_pcs[0]));
    check("m1_brcnt",  32'(bc1),  32'(m_bcnt[0]));
    check("m1_miscnt", 32'(mc1),  32'(m_mcnt[0]));
    check("m0_pred",   32'(pt0),  32'(e_pd[1]));
    check("m0_cond",   32'(cm0),  32'(e_cond[1]));
    check("m0_mis",    32'(mis0), 32'(e_mis[1]));
    check("m0_pcsrc",  32'(pcs0), 32'(e_pcs[1]));
    check("m0_brcnt",  32'(bc0),  32'(m_bcnt[1]));
    check("m0_miscnt", 32'(mc0),  32'(m_mcnt[1]));
  endtask

  // Clock-edge behaviour of the model, using the pre-edge expectations
  task automatic model_edge();
    int ie;
    ie = int'((pc_E >> 2) % 16);
    if (m_v[0] && funct3_E != 3'd2 && funct3_E != 3'd3) begin
      if (e_cond[0]) m_ctr[ie] = (m_ctr[ie] < 3) ? m_ctr[ie] + 1 : 3;
      else           m_ctr[ie] = (m_ctr[ie] > 0) ? m_ctr[ie] - 1 : 0;
    end
    for (int k = 0; k < 2; k++) begin
      if (stats_clr) begin
        m_bcnt[k] = 0; m_mcnt[k] = 0;
      end else begin
        if (m_v[k] && m_bcnt[k] < m_max[k]) m_bcnt[k]++;
        if (e_mis[k] && m_mcnt[k] < m_max[k]) m_mcnt[k]++;
      end
      if (!stall_D) begin
        m_v[k] = branch_D && !flush_D;
        m_pred[k] = e_pd[k];
      end
      if (e_mis[k]) m_v[k] = 0;
    end
  endtask

  // Drive inputs; ALU flags are derived from the operands of A-B
  task automatic drive(input logic br, input logic jmp, input logic stl, input logic fl,
                       input logic clr, input logic [31:0] pcd, input logic [31:0] pce,
                       input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
    logic [31:0] d;
    d = a - b;
    branch_D = br; jump_D = jmp; stall_D = stl; flush_D = fl; stats_clr = clr;
    pc_D = pcd; pc_E = pce; funct3_E = f3; s_a = a; s_b = b;
    N = d[31];
    Z = (d == 32'd0);
    C = (a >= b);
    V = (a[31] != b[31]) && (d[31] != a[31]);
  endtask

  task automatic step(input logic br, input logic jmp, input logic stl, input logic fl,
                      input logic clr, input logic [31:0] pcd, input logic [31:0] pce,
                      input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
    drive(br, jmp, stl, fl, clr, pcd, pce, f3, a, b);
    #2;
    check_all();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  logic [31:0] pce_q;
  logic [31:0] rpcd, ra, rb;
  logic        rbr, rjmp, rstl, rfl, rclr;
  logic [2:0]  rf3;

  initial begin
    // Reset state
    reset = 1'b1;
    drive(0, 0, 0, 0, 0, 32'h0, 32'h0, 3'd0, 32'd0, 32'd0);
    #2;
    model_reset();
    check_all();
    @(posedge clk); @(posedge clk); #1;
    reset = 1'b0;

    // BEQ at 0x40: predicted not-taken, resolves taken -> branch-target recovery
    step(1, 0, 0, 0, 0, 32'h40, 32'h0,  3'd0, 32'd0, 32'd0);
    step(0, 0, 0, 0, 0, 32'h0,  32'h40, 3'd0, 32'd5, 32'd5);
    // Three more taken resolutions drive counter[0] to saturation
    repeat (3) begin
      step(1, 0, 0, 0, 0, 32'h40, 32'h0,  3'd0, 32'd0, 32'd0);
      step(0, 0, 0, 0, 0, 32'h0,  32'h40, 3'd0, 32'd7, 32'd7);
    end
    // Not-taken resolution of a predicted-taken branch -> pc_E+4 recovery
    step(1, 0, 0, 0, 0, 32'h40, 32'h0,  3'd0, 32'd0, 32'd0);
    step(0, 0, 0, 0, 0, 32'h0,  32'h40, 3'd0, 32'd7, 32'd8);
    step(1, 0, 0, 0, 0, 32'h40, 32'h0,  3'd0, 32'd0, 32'd0);

    // Unsigned conditions with C=0 (1 < 2 unsigned), then reserved funct3
    step(1, 0, 0, 0, 0, 32'h80, 32'h40, 3'd0, 32'd0, 32'd0);
    step(1, 0, 0, 0, 0, 32'h80, 32'h80, 3'd6, 32'd1, 32'd2);
    step(1, 0, 0, 0, 0, 32'h80, 32'h80, 3'd7, 32'd1, 32'd2);
    step(0, 0, 0, 0, 0, 32'h0,  32'h80, 3'd2, 32'd3, 32'd3);
    step(1, 0, 0, 0, 0, 32'h80, 32'h0,  3'd0, 32'd0, 32'd1);
    // Signed conditions across the sign boundary
    step(1, 0, 0, 0, 0, 32'h84, 32'h80, 3'd4, 32'hFFFF_FFFF, 32'd1);
    step(0, 0, 0, 0, 0, 32'h0,  32'h84, 3'd5, 32'hFFFF_FFFF, 32'd1);

    // JAL in D alongside a mispredict in E: recovery code wins
    step(1, 0, 0, 0, 0, 32'h44, 32'h0,  3'd0, 32'd0, 32'd0);
    step(0, 1, 0, 0, 0, 32'h48, 32'h44, 3'd1, 32'd2, 32'd3);

    // Mispredict while stalled, then the E entry must be gone
    step(1, 0, 0, 0, 0, 32'h4C, 32'h0,  3'd0, 32'd0, 32'd0);
    step(0, 0, 1, 0, 0, 32'h4C, 32'h4C, 3'd0, 32'd4, 32'd4);
    step(0, 0, 0, 0, 0, 32'h0,  32'h4C, 3'd0, 32'd4, 32'd4);
    // Flushed branch never enters E
    step(1, 0, 0, 1, 0, 32'h50, 32'h0,  3'd0, 32'd0, 32'd0);
    step(0, 0, 0, 0, 0, 32'h0,  32'h50, 3'd0, 32'd6, 32'd6);

    // Saturate the 4-bit statistics of the static instance
    repeat (20) step(1, 0, 0, 0, 0, 32'h54, 32'h54, 3'd1, 32'd1, 32'd1);
    // Clear with a branch resolving in the same cycle
    step(0, 0, 0, 0, 1, 32'h0, 32'h54, 3'd0, 32'd1, 32'd1);
    step(0, 0, 0, 0, 0, 32'h0, 32'h0,  3'd0, 32'd0, 32'd0);

    // Train counter[3] to strongly taken, then reset with a branch in E
    repeat (3) begin
      step(1, 0, 0, 0, 0, 32'h0C, 32'h0,  3'd0, 32'd0, 32'd0);
      step(0, 0, 0, 0, 0, 32'h0,  32'h0C, 3'd0, 32'd9, 32'd9);
    end
    step(1, 0, 0, 0, 0, 32'h0C, 32'h0, 3'd0, 32'd0, 32'd0);
    drive(0, 0, 0, 0, 0, 32'h0, 32'h0C, 3'd0, 32'd9, 32'd8);
    #2;
    reset = 1'b1;
    #1;
    model_reset();
    check_all();
    @(posedge clk); #1;
    reset = 1'b0;
    step(1, 0, 0, 0, 0, 32'h0C, 32'h0, 3'd0, 32'd0, 32'd0);

    // Randomised traffic with pc_E following pc_D
    pce_q = 32'h0;
    for (int i = 0; i < 600; i++) begin
      rbr  = 1'($urandom_range(0, 1));
      rjmp = !rbr && ($urandom_range(0, 7) == 0);
      rstl = ($urandom_range(0, 7) == 0);
      rfl  = ($urandom_range(0, 9) == 0);
      rclr = ($urandom_range(0, 59) == 0);
      rpcd = 32'($urandom_range(0, 31)) << 2;
      rf3  = 3'($urandom_range(0, 7));
      ra   = ($urandom_range(0, 1) == 0) ? 32'($urandom_range(0, 15)) - 32'd8 : $urandom;
      rb   = ($urandom_range(0, 3) == 0) ? ra : (($urandom_range(0, 1) == 0) ? 32'($urandom_range(0, 15)) - 32'd8 : $urandom);
      step(rbr, rjmp, rstl, rfl, rclr, rpcd, pce_q, rf3, ra, rb);
      if (!rstl) pce_q = rpcd;
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  // Absolute time bound so the run always ends
  initial begin
    #200000;
    $display("FAIL timeout: observed no completion expected completion");
    $fatal(1, "time limit reached");
  end

endmodule
